// File: rtl/clock_gating_ctrl.sv
// Idle-detect gate-enable controller with stop/ack quiesce and wake settle window.
// Define CLOCK_GATING_CTRL_STATS_EN to add the saturating gated-cycle counter.
module clock_gating_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2
`ifdef CLOCK_GATING_CTRL_STATS_EN
   , parameter int STAT_W = 32
`endif
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cfg_en_i,
   input  logic       busy_i,
   input  logic       wake_i,
   input  logic       stop_ack_i,
   output logic       stop_req_o,
   output logic       cg_en_o,
   output logic       ready_o,
   output logic [1:0] state_o
`ifdef CLOCK_GATING_CTRL_STATS_EN
   , output logic [STAT_W-1:0] gated_cycles_o
`endif
);

   localparam int IW = $clog2(IDLE_CYCLES + 1);
   localparam int WW = $clog2(WAKE_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
   localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      DRAIN  = 2'd1,
      GATED  = 2'd2,
      WAKE   = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic [WW-1:0] wake_cnt_q, wake_cnt_d;
   logic          idle;

   assign idle = cfg_en_i & ~busy_i & ~wake_i;

   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      unique case (state_q)
         ACTIVE: begin
            if (!idle) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_LAST) begin
               state_d    = DRAIN;
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            // abort wins over a same-cycle ack
            if (busy_i || wake_i || !cfg_en_i) begin
               state_d    = ACTIVE;
               idle_cnt_d = '0;
            end else if (stop_ack_i) begin
               state_d = GATED;
            end
         end
         GATED: begin
            if (wake_i || !cfg_en_i) begin
               state_d    = WAKE;
               wake_cnt_d = '0;
            end
         end
         WAKE: begin
            if (wake_cnt_q == WAKE_LAST) begin
               state_d    = ACTIVE;
               idle_cnt_d = '0;
               wake_cnt_d = '0;
            end else begin
               wake_cnt_d = wake_cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ACTIVE;
         idle_cnt_q <= '0;
         wake_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         wake_cnt_q <= wake_cnt_d;
      end
   end

   assign cg_en_o    = (state_q != GATED);
   assign ready_o    = (state_q == ACTIVE);
   assign stop_req_o = (state_q == DRAIN) || (state_q == GATED);
   assign state_o    = state_q;

`ifdef CLOCK_GATING_CTRL_STATS_EN
   logic [STAT_W-1:0] gated_cnt_q, gated_cnt_d;

   always_comb begin
      gated_cnt_d = gated_cnt_q;
      if ((state_q == GATED) && !(&gated_cnt_q)) begin
         gated_cnt_d = gated_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         gated_cnt_q <= '0;
      end else begin
         gated_cnt_q <= gated_cnt_d;
      end
   end

   assign gated_cycles_o = gated_cnt_q;
`endif

endmodule

// File: tb/tb_clock_gating_ctrl.sv
// Scoreboard bench for clock_gating_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_clock_gating_ctrl;

   localparam logic [1:0] A = 2'd0;
   localparam logic [1:0] D = 2'd1;
   localparam logic [1:0] G = 2'd2;
   localparam logic [1:0] W = 2'd3;

   logic clk = 1'b0;
   logic rst_n, cfg_en, busy, wake, ack;
   logic stop_req, cg_en, ready;
   logic [1:0] state;
`ifdef CLOCK_GATING_CTRL_STATS_EN
   logic [31:0] gated_cycles;
`endif

   clock_gating_ctrl #(
      .IDLE_CYCLES(4),
      .WAKE_CYCLES(2)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .cfg_en_i   (cfg_en),
      .busy_i     (busy),
      .wake_i     (wake),
      .stop_ack_i (ack),
      .stop_req_o (stop_req),
      .cg_en_o    (cg_en),
      .ready_o    (ready),
      .state_o    (state)
`ifdef CLOCK_GATING_CTRL_STATS_EN
      , .gated_cycles_o(gated_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] st;
      int         stat;
      string      nm;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // expected {state, cg_en, ready, stop_req} for a given state
   function automatic logic [4:0] outs(input logic [1:0] st);
      unique case (st)
         A: outs = {A, 3'b110};
         D: outs = {D, 3'b101};
         G: outs = {G, 3'b001};
         default: outs = {W, 3'b100};
      endcase
   endfunction

   always @(negedge clk) begin
      if (q.size() != 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [4:0] got, want;
         e = q.pop_front();
         got  = {state, cg_en, ready, stop_req};
         want = outs(e.st);
         n_chk++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: stale entry cyc %0d at %0d", e.nm, e.cyc, cyc);
         end else if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got st/cg/rdy/req=%b required %b",
                     e.nm, got, want);
         end
`ifdef CLOCK_GATING_CTRL_STATS_EN
         if (e.stat >= 0) begin
            n_chk++;
            if (gated_cycles !== 32'(e.stat)) begin
               n_fail++;
               $display("FAIL %s stats: got %0d required %0d",
                        e.nm, gated_cycles, e.stat);
            end
         end
`endif
      end
   end

   task automatic step(input logic c, b, w, k, r,
                       input logic [1:0] st, input int stat,
                       input string nm);
      cfg_en = c;
      busy   = b;
      wake   = w;
      ack    = k;
      rst_n  = r;
      q.push_back('{cyc + 1, st, stat, nm});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [1:0] st, input string nm);
      step(1, 0, 0, 0, 1, st, -1, nm);
   endtask

   task automatic to_drain(input string nm);
      repeat (3) idle(A, nm);
      idle(D, nm);
   endtask

   initial begin
      step(1, 0, 0, 0, 0, A, 0, "reset");
      step(1, 0, 0, 1, 0, A, 0, "reset2");
      step(1, 1, 0, 1, 1, A, -1, "ack_in_active");

      // basic gate: DRAIN at cycle 4, ack at 6, gated at 7
      to_drain("idle_to_drain");
      idle(D, "drain_hold0");
      idle(D, "drain_hold1");
      step(1, 0, 0, 1, 1, G, -1, "ack_gate");
      step(1, 1, 0, 1, 1, G, -1, "gated_ignore_busy");
      // wake: cg on at G+1, ready at G+3
      step(1, 0, 1, 0, 1, W, -1, "wake_g1");
      step(1, 1, 1, 0, 1, W, -1, "wake_g2");
      idle(A, "wake_g3_ready");

      // hysteresis
      idle(A, "hyst_i1");
      idle(A, "hyst_i2");
      step(1, 1, 0, 0, 1, A, -1, "hyst_busy");
      to_drain("hyst_restart");

      // abort beats ack
      step(1, 0, 1, 1, 1, A, -1, "abort_wake_ack");
      to_drain("redrain");
      step(0, 0, 0, 0, 1, A, -1, "abort_cfg");

      // cfg off while gated goes through WAKE
      to_drain("cfg_drain");
      step(1, 0, 0, 1, 1, G, -1, "cfg_gate");
      step(0, 0, 0, 0, 1, W, -1, "cfg_wake1");
      step(0, 0, 0, 0, 1, W, -1, "cfg_wake2");
      step(0, 0, 0, 0, 1, A, -1, "cfg_active");
      for (int i = 0; i < 100; i++) begin
         step(0, 0, 0, 0, 1, A, -1, "cfg_off_hold");
      end

      // reset while gated, then count gated cycles
      to_drain("rst_drain");
      step(1, 0, 0, 1, 1, G, -1, "rst_gate");
      idle(G, "rst_gated1");
      step(1, 0, 0, 0, 0, A, 0, "rst_in_gated");
      to_drain("stat_drain");
      step(1, 0, 0, 1, 1, G, 0, "stat_gate");
      for (int i = 1; i <= 10; i++) begin
         step(1, 0, 0, 0, 1, G, (i == 10) ? 10 : -1, "stat_gated");
      end
      step(1, 0, 1, 0, 1, W, 11, "stat_wake");

      repeat (3) @(posedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_queue: %0d left required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_gating_ctrl.md
Name: clock_gating_ctrl

Overview:
Idle-detection controller that sits directly upstream of the clock gating cell and drives its enable input. It runs on the free-running clock, watches the activity of one gated unit, and quiesces it with a stop request/acknowledge handshake. After the handshake it drops the gate enable, and on a wake request it re-enables the clock and holds off new work for a settle window. One instance is used per gated compute unit; the scan enable is routed to the gating cell separately and never passes through this block.

Parameters:
IDLE_CYCLES, 16, consecutive idle cycles required before a stop is requested; legal range is 1 or more.
WAKE_CYCLES, 2, cycles the clock runs after wake before ready_o is asserted; legal range is 1 or more.
STAT_W, 32, width of the gated-cycle counter (optional feature only).

Ports:
clk_i  input  1  free-running clock (ungated)
rst_ni  input  1  synchronous active-low reset
cfg_en_i  input  1  auto-gating enable; 0 forces the clock on
busy_i  input  1  unit activity; 1 means not idle
wake_i  input  1  new work pending for the unit
stop_ack_i  input  1  unit has quiesced in response to stop_req_o
stop_req_o  output  1  quiesce request to the unit
cg_en_o  output  1  to gating cell en_i; 1 means clock runs
ready_o  output  1  unit is clocked and may accept work
state_o  output  2  FSM state for debug: ACTIVE=0, DRAIN=1, GATED=2, WAKE=3
gated_cycles_o  output  STAT_W  gated-cycle count (present only with the optional feature)

Behaviour:
- Clocking and reset:
  - One clock, clk_i. Reset is synchronous and active-low on rst_ni.
  - All outputs are flops or a decode of the state register only. There is no combinational path from any input to any output.
- Reset values: state ACTIVE, cg_en_o=1, ready_o=1, stop_req_o=0, idle_cnt=0, wake_cnt=0.
- Reset asserted in any state: ACTIVE on the next edge, with the clock forced on.
- Idle condition: idle = cfg_en_i & ~busy_i & ~wake_i.
- ACTIVE state:
  - Outputs: cg_en_o=1, ready_o=1, stop_req_o=0.
  - idle_cnt increments on each idle cycle and clears on any non-idle cycle.
  - On a cycle with idle=1 and idle_cnt==IDLE_CYCLES-1, go to DRAIN. DRAIN is therefore entered on the edge after the IDLE_CYCLES-th consecutive idle cycle.
  - idle_cnt width is $clog2(IDLE_CYCLES+1). It never wraps, because the counter clears on leaving ACTIVE.
- DRAIN state:
  - Outputs: cg_en_o=1, ready_o=0, stop_req_o=1.
  - If busy_i, wake_i, or ~cfg_en_i: abort to ACTIVE and clear idle_cnt. Abort has priority over stop_ack_i in the same cycle.
  - Otherwise, if stop_ack_i: go to GATED.
  - With no ack, remain in DRAIN indefinitely.
- GATED state:
  - Outputs: cg_en_o=0, ready_o=0, stop_req_o=1 (held so the unit stays quiesced).
  - busy_i and stop_ack_i are ignored (the unit is unclocked).
  - On wake_i or ~cfg_en_i: go to WAKE and clear wake_cnt.
- WAKE state:
  - Outputs: cg_en_o=1, ready_o=0, stop_req_o=0.
  - wake_cnt increments each cycle. When wake_cnt==WAKE_CYCLES-1, go to ACTIVE and clear idle_cnt.
  - wake_i and busy_i are ignored during WAKE. The window cannot be aborted or retriggered.
- Latency:
  - Ack at cycle M in DRAIN: cg_en_o=0 from M+1.
  - wake_i at cycle G in GATED: cg_en_o=1 from G+1, ready_o=1 from G+1+WAKE_CYCLES.
- cfg_en_i deasserted:
  - Never gates from ACTIVE.
  - Leaves DRAIN to ACTIVE in 1 cycle.
  - Leaves GATED via WAKE, so the settle window is always honoured.
- stop_ack_i asserted outside DRAIN and GATED has no effect.

Optional Feature:
Macro: CLOCK_GATING_CTRL_STATS_EN.
- Defined:
  - gated_cycles_o port exists.
  - Counter increments on every cycle where registered cg_en_o==0.
  - Saturates at all-ones and never wraps.
  - Cleared to 0 by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then IDLE_CYCLES=4, cfg_en_i=1, busy_i=0 from cycle 0 -> state_o=DRAIN and stop_req_o=1 at cycle 4. Ack at cycle 6 -> cg_en_o=0 and ready_o=0 at cycle 7.
- Idle hysteresis: busy_i pulse at idle cycle 3 of 4 -> idle_cnt clears; DRAIN is reached only after 4 further consecutive idle cycles.
- DRAIN abort: wake_i and stop_ack_i both 1 in the same DRAIN cycle -> ACTIVE next cycle, cg_en_o stays 1, stop_req_o=0.
- Wake from GATED, WAKE_CYCLES=2: wake_i at cycle G -> cg_en_o=1 at G+1, ready_o=0 at G+1 and G+2, ready_o=1 at G+3.
- cfg_en_i=0 while GATED -> WAKE next cycle, then ACTIVE; with cfg_en_i held 0 the block stays ACTIVE for 100 idle cycles.
- rst_ni=0 for 1 cycle while GATED -> next edge: cg_en_o=1, ready_o=1, stop_req_o=0, state_o=0. With CLOCK_GATING_CTRL_STATS_EN, gated_cycles_o=0 after reset and equals 10 after 10 gated cycles.
